// File: rtl/rightmost_bit_op_serial.sv
// rightmost_bit_op_serial: eight rightmost-bit operations computed one slice per cycle with a registered carry
module rightmost_bit_op_serial #(
  parameter int WORD_WIDTH    = 32,
  parameter int SEGMENT_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_word,
  input  logic [2:0]            input_op,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_word,
  output logic                  output_unchanged
);
  localparam int NUM_SEGMENTS = WORD_WIDTH / SEGMENT_WIDTH;
  localparam int SW = NUM_SEGMENTS > 1 ? $clog2(NUM_SEGMENTS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] x_q, x_d, word_q, word_d;
  logic [2:0] op_q, op_d;
  logic [SW-1:0] seg_q, seg_d;
  logic carry_q, carry_d;
  logic [SEGMENT_WIDTH-1:0] xs, ts, rs;
  logic co, dec, last, accept;
  always_comb begin
    xs = x_q[seg_q*SEGMENT_WIDTH +: SEGMENT_WIDTH];
    dec = op_q inside {3'd0, 3'd3, 3'd6};
    {co, ts} = {1'b0, op_q == 3'd4 ? ~xs : xs} + {1'b0, {SEGMENT_WIDTH{dec}}}
             + {{SEGMENT_WIDTH{1'b0}}, carry_q};
    rs = (op_q inside {3'd1, 3'd3}) ? xs | ts :
         (op_q inside {3'd5, 3'd6}) ? ~xs & ts :
         op_q == 3'd7 ? xs & ~ts : xs & ts;
    last = seg_q == SW'(NUM_SEGMENTS - 1);
    input_ready = state_q == IDLE || (state_q == DONE && output_ready);
    accept = input_valid && input_ready;
    output_valid = state_q == DONE;
    output_word = word_q;
    output_unchanged = output_valid && word_q == x_q;
    state_d = state_q;
    x_d = x_q;
    op_d = op_q;
    seg_d = seg_q;
    carry_d = carry_q;
    word_d = word_q;
    if (state_q == RUN) begin
      word_d[seg_q*SEGMENT_WIDTH +: SEGMENT_WIDTH] = rs;
      carry_d = co;
      seg_d = last ? '0 : seg_q + SW'(1);
      state_d = last ? DONE : RUN;
    end
    if (state_q == DONE && output_ready) state_d = IDLE;
    if (accept) begin
      x_d = input_word;
      op_d = input_op;
      seg_d = '0;
      carry_d = !(input_op inside {3'd0, 3'd3, 3'd6});
      state_d = RUN;
    end
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      x_q <= '0;
      op_q <= '0;
      seg_q <= '0;
      carry_q <= 1'b0;
      word_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      op_q <= op_d;
      seg_q <= seg_d;
      carry_q <= carry_d;
      word_q <= word_d;
    end
  end
endmodule

// File: tb/tb_rightmost_bit_op_serial.sv
// tb_rightmost_bit_op_serial: directed and randomized checks against a latency/queue reference model
module tb_rightmost_bit_op_serial;
  localparam int W = 32;
  localparam int N = 4;
  logic clock = 0, clear = 1, input_valid = 0, output_ready = 0;
  logic [2:0] input_op = 0;
  logic [W-1:0] input_word = 0;
  logic input_ready, output_valid, output_unchanged;
  logic [W-1:0] output_word;
  int checks = 0, failures = 0;
  bit armed = 0;
  bit have = 0;
  int cnt = 0;
  logic [W-1:0] exp_word = 0, exp_x = 0;

  rightmost_bit_op_serial #(.WORD_WIDTH(W), .SEGMENT_WIDTH(8)) dut (
    .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(input_ready),
    .input_word(input_word), .input_op(input_op), .output_valid(output_valid),
    .output_ready(output_ready), .output_word(output_word), .output_unchanged(output_unchanged)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] x);
    case (op)
      3'd0: return x & (x - 1);
      3'd1: return x | (x + 1);
      3'd2: return x & (x + 1);
      3'd3: return x | (x - 1);
      3'd4: return x & (-x);
      3'd5: return ~x & (x + 1);
      3'd6: return ~x & (x - 1);
      default: return x & ~(x + 1);
    endcase
  endfunction

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  // One transaction in flight at most; result due N edges after acceptance.
  always @(posedge clock) begin : model
    bit hs, acc;
    if (clear) have = 0;
    else begin
      hs = have && cnt == 0 && output_ready;
      acc = input_valid && (!have || hs);
      if (hs) have = 0;
      else if (have && cnt > 0) cnt--;
      if (acc) begin
        have = 1;
        cnt = N;
        exp_x = input_word;
        exp_word = ref_f(input_op, input_word);
      end
    end
  end

  always @(negedge clock) begin : compare
    bit ev;
    if (armed) begin
      ev = have && cnt == 0;
      chk("output_valid", W'(output_valid), W'(ev));
      chk("input_ready", W'(input_ready), W'(!have || (ev && output_ready)));
      if (ev) begin
        chk("output_word", output_word, exp_word);
        chk("output_unchanged", W'(output_unchanged), W'(exp_word == exp_x));
      end
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!output_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic txn(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] e, input logic eu);
    int lat;
    input_valid = 1; input_op = op; input_word = x;
    @(posedge clock); #1;
    input_valid = 0; input_op = 3'($urandom); input_word = $urandom;
    wait_valid(lat);
    chk($sformatf("op%0d latency", op), W'(lat), W'(N));
    chk($sformatf("op%0d x=%h result", op, x), output_word, e);
    chk($sformatf("op%0d x=%h unchanged", op, x), W'(output_unchanged), W'(eu));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    chk("model op3 A8", ref_f(3, 32'hA8), 32'hAF);
    chk("model op4", ref_f(4, 32'h1234_0000), 32'h0004_0000);
    chk("model op6", ref_f(6, 32'h40), 32'h3F);
    chk("model op2", ref_f(2, 32'h0F0F_00FF), 32'h0F0F_0000);
    repeat (2) @(posedge clock);
    #1 clear = 0; armed = 1;
    chk("reset output_valid", W'(output_valid), 0);
    chk("reset output_word", output_word, 0);
    chk("reset output_unchanged", W'(output_unchanged), 0);
    chk("reset input_ready", W'(input_ready), 1);
    output_ready = 1;
    txn(3, 32'h0000_00A8, 32'h0000_00AF, 0);
    txn(0, 32'h0001_0000, 32'h0000_0000, 0);
    txn(3, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    txn(3, 32'h0000_0001, 32'h0000_0001, 1);
    txn(4, 32'h1234_0000, 32'h0004_0000, 0);
    txn(5, 32'h0000_00FF, 32'h0000_0100, 0);
    txn(7, 32'h0000_FFFF, 32'h0000_FFFF, 1);
    @(posedge clock); #1;
    output_ready = 0;
    input_valid = 1; input_op = 2; input_word = 32'h0F0F_00FF;
    @(posedge clock); #1;
    input_valid = 0;
    wait_valid(lat);
    chk("backpressure latency", W'(lat), W'(N));
    repeat (5) begin
      @(posedge clock); #1;
      chk("held output_word", output_word, 32'h0F0F_0000);
      chk("held input_ready", W'(input_ready), 0);
    end
    output_ready = 1;
    input_valid = 1; input_op = 6; input_word = 32'h40;
    @(posedge clock); #1;
    input_valid = 0;
    chk("overlap output_valid low", W'(output_valid), 0);
    wait_valid(lat);
    chk("overlap latency", W'(lat), W'(N));
    chk("overlap result", output_word, 32'h3F);
    input_valid = 1; input_op = 0; input_word = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    input_valid = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1;
    @(posedge clock); #1;
    clear = 0;
    chk("clear output_valid", W'(output_valid), 0);
    chk("clear output_word", output_word, 0);
    chk("clear output_unchanged", W'(output_unchanged), 0);
    chk("clear input_ready", W'(input_ready), 1);
    txn(1, 32'h0000_FFFF, 32'h0001_FFFF, 0);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      input_valid = 1'($urandom_range(0, 1));
      input_op = 3'($urandom_range(0, 7));
      input_word = pick();
      output_ready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 99) == 0;
    end
    @(posedge clock); #1;
    clear = 0; input_valid = 0; output_ready = 1;
    repeat (10) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
